// File: rtl/freq_band_detector.sv
// rtl/freq_band_detector.sv - beacon frequency band detector
// Counts synchronized rising edges of `signal` over a fixed gate window and classifies the count.
module freq_band_detector #(
  parameter int GATE_CYCLES = 10000000,
  parameter int F1_EDGES    = 100,
  parameter int F2_EDGES    = 200,
  parameter int F3_EDGES    = 300,
  parameter int TOL         = 10,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  output logic       oneK,
  output logic       twoK,
  output logic       threeK,
  output logic [1:0] first_intersection,
  output logic       valid
);

  localparam int WC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Band bounds are clamped at zero so a tolerance wider than the nominal count stays sane.
  localparam logic [31:0] F1_LO = (F1_EDGES > TOL) ? 32'(F1_EDGES - TOL) : 32'd0;
  localparam logic [31:0] F1_HI = 32'(F1_EDGES + TOL);
  localparam logic [31:0] F2_LO = (F2_EDGES > TOL) ? 32'(F2_EDGES - TOL) : 32'd0;
  localparam logic [31:0] F2_HI = 32'(F2_EDGES + TOL);
  localparam logic [31:0] F3_LO = (F3_EDGES > TOL) ? 32'(F3_EDGES - TOL) : 32'd0;
  localparam logic [31:0] F3_HI = 32'(F3_EDGES + TOL);

  logic             sync1_q, sync2_q, sync3_q;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] total;
  logic [31:0]      total_ext;
  logic [2:0]       flags_q, flags_d;
  logic [1:0]       band_d;
  logic [1:0]       first_q, first_d;
  logic             valid_q;
  logic             rise;
  logic             close;

  assign rise  = sync2_q & ~sync3_q;
  assign close = (wc_q == WC_LAST);

  always_comb begin
    total = edge_cnt_q;
    if (rise && (edge_cnt_q != CNT_MAX)) begin
      total = edge_cnt_q + 1'b1;
    end
    total_ext = 32'(total);

    wc_d       = close ? '0 : wc_q + 1'b1;
    edge_cnt_d = close ? '0 : total;

    if ((total_ext >= F1_LO) && (total_ext <= F1_HI)) begin
      band_d = 2'd1;
    end else if ((total_ext >= F2_LO) && (total_ext <= F2_HI)) begin
      band_d = 2'd2;
    end else if ((total_ext >= F3_LO) && (total_ext <= F3_HI)) begin
      band_d = 2'd3;
    end else begin
      band_d = 2'd0;
    end

    flags_d = flags_q;
    first_d = first_q;
    if (close) begin
      case (band_d)
        2'd1:    flags_d = 3'b001;
        2'd2:    flags_d = 3'b010;
        2'd3:    flags_d = 3'b100;
        default: flags_d = 3'b000;
      endcase
      if ((first_q == 2'd0) && (band_d != 2'd0)) begin
        first_d = band_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      wc_q       <= '0;
      edge_cnt_q <= '0;
      flags_q    <= 3'b000;
      first_q    <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= signal;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      wc_q       <= wc_d;
      edge_cnt_q <= edge_cnt_d;
      flags_q    <= flags_d;
      first_q    <= first_d;
      valid_q    <= close;
    end
  end

  assign oneK               = flags_q[0];
  assign twoK               = flags_q[1];
  assign threeK             = flags_q[2];
  assign first_intersection = first_q;
  assign valid              = valid_q;

endmodule

// File: tb/tb_freq_band_detector.sv
// tb/tb_freq_band_detector.sv - scoreboard bench for freq_band_detector
// Each driven window pushes its expected band; the monitor pops on every valid pulse.
module tb_freq_band_detector;

  localparam int GATE = 1000;
  localparam int F1   = 10;
  localparam int F2   = 20;
  localparam int F3   = 30;
  localparam int TOL  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b0;
  logic       oneK, twoK, threeK, valid;
  logic [1:0] first_intersection;

  freq_band_detector #(
    .GATE_CYCLES(GATE), .F1_EDGES(F1), .F2_EDGES(F2), .F3_EDGES(F3), .TOL(TOL), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal),
    .oneK(oneK), .twoK(twoK), .threeK(threeK),
    .first_intersection(first_intersection), .valid(valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         exp_cyc;
    logic [2:0] flags;
    logic [1:0] first;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_first = 2'd0;
  logic [2:0] hold_flags = 3'b000;
  logic [1:0] hold_first = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input int n);
    if (n >= F1 - TOL && n <= F1 + TOL) return 2'd1;
    if (n >= F2 - TOL && n <= F2 + TOL) return 2'd2;
    if (n >= F3 - TOL && n <= F3 + TOL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic pulse_at(input int k, input int n, input int period,
                                    input int offset, input int width);
    for (int j = 0; j < n; j++) begin
      if (k >= offset + j * period && k < offset + j * period + width) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_reset(input int cycles, input bit toggle);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (toggle) signal = ~signal;
      @(negedge clk);
    end
    check_eq("rst_flags", {threeK, twoK, oneK}, 3'b000);
    check_eq("rst_first", first_intersection, 2'd0);
    check_eq("rst_valid", valid, 1'b0);
    rst_n      = 1'b1;
    signal     = 1'b0;
    exp_first  = 2'd0;
    hold_flags = 3'b000;
    hold_first = 2'd0;
  endtask

  // Called on the negedge of the wc=0 cycle; returns on the negedge of the next window's wc=0 cycle.
  // A rise driven in window cycle k reaches the edge counter in cycle k+2.
  task automatic run_window(input int n, input int period, input int offset, input int width,
                            input bit const_hi, input int abort_k);
    int         cnt;
    logic [1:0] band;
    exp_t       e;
    logic [2:0] prev_flags;
    logic [1:0] prev_first;
    prev_flags = hold_flags;
    prev_first = hold_first;
    cnt  = const_hi ? (signal ? 0 : 1) : n;
    band = classify(cnt);
    if (abort_k < 0) begin
      if (exp_first == 2'd0 && band != 2'd0) exp_first = band;
      e.exp_cyc = cyc + GATE;
      e.flags   = (band == 2'd0) ? 3'b000 : (3'b001 << (band - 2'd1));
      e.first   = exp_first;
      sb.push_back(e);
    end
    for (int k = 0; k < GATE; k++) begin
      if (k == 500) begin
        check_eq("hold_flags", {threeK, twoK, oneK}, prev_flags);
        check_eq("hold_first", first_intersection, prev_first);
      end
      if (k == abort_k) begin
        do_reset(3, 1'b0);
        return;
      end
      signal = const_hi ? 1'b1 : pulse_at(k, n, period, offset, width);
      @(negedge clk);
    end
    hold_flags = e.flags;
    hold_first = e.first;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
      check_eq("valid_missing", 1'b0, 1'b1);
      void'(sb.pop_front());
    end
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("valid_spurious", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("valid_cycle", cyc, e.exp_cyc);
        check_eq("flags", {threeK, twoK, oneK}, e.flags);
        check_eq("first", first_intersection, e.first);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(5, 1'b1);
    run_window(10, 100, 0, 50, 1'b0, -1);
    run_window(20, 50, 0, 25, 1'b0, -1);
    run_window(8, 100, 0, 50, 1'b0, -1);
    run_window(12, 80, 0, 40, 1'b0, -1);
    run_window(7, 100, 0, 50, 1'b0, -1);
    run_window(13, 70, 0, 35, 1'b0, -1);
    run_window(15, 60, 0, 30, 1'b0, -1);
    run_window(0, 100, 0, 50, 1'b0, -1);
    run_window(0, 100, 0, 50, 1'b1, -1);
    run_window(0, 100, 0, 50, 1'b0, -1);
    // Eighth rise lands on the closing cycle; dropping it would leave 7 (none).
    run_window(8, 100, 297, 2, 1'b0, -1);
    run_window(10, 100, 0, 50, 1'b0, -1);
    do_reset(2, 1'b0);
    run_window(30, 33, 0, 16, 1'b0, -1);
    run_window(10, 100, 0, 50, 1'b0, 500);
    run_window(10, 100, 0, 50, 1'b0, -1);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
